// File: rtl/dual_lane_deserialiser.sv
// Two-lane serial-to-parallel receiver: frames MSB-first words on lanes A and B,
// hands pairs downstream over valid/ready and polices the down/up counter sequences.
module dual_lane_deserialiser #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame,
    input  logic             in_a,
    input  logic             in_b,
    output logic [WIDTH-1:0] word_a,
    output logic [WIDTH-1:0] word_b,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             seq_err,
    output logic             frame_err,
    output logic [ERR_W-1:0] seq_cnt,
    output logic [ERR_W-1:0] frm_cnt,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
    logic [WIDTH-1:0] word_a_q, word_a_d, word_b_q, word_b_d;
    logic [WIDTH-1:0] prev_a_q, prev_a_d, prev_b_q, prev_b_d;
    logic             have_prev_q, have_prev_d;
    logic             word_valid_q, word_valid_d;
    logic             seq_err_q, seq_err_d;
    logic             frame_err_q, frame_err_d;
    logic [ERR_W-1:0] seq_cnt_q, seq_cnt_d, frm_cnt_q, frm_cnt_d;
    logic             overflow_q, overflow_d;

    logic [WIDTH-1:0] full_a_s, full_b_s;
    logic             load_s, shift_s, complete_s, clear_prev_s, capture_s, drop_s;

    // Lane A counts down, lane B counts up; both wrap modulo 2^WIDTH.
    function automatic logic seq_break(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb);
        logic [WIDTH-1:0] exp_a;
        logic [WIDTH-1:0] exp_b;
        exp_a = pa - WIDTH'(1);
        exp_b = pb + WIDTH'(1);
        return (a != exp_a) || (b != exp_b);
    endfunction

    // Framing FSM, word capture, sequence check and error accounting.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        load_s       = 1'b0;
        shift_s      = 1'b0;
        complete_s   = 1'b0;
        clear_prev_s = 1'b0;
        frame_err_d  = 1'b0;
        full_a_s     = {sh_a_q[WIDTH-2:0], in_a};
        full_b_s     = {sh_b_q[WIDTH-2:0], in_b};

        case (state_q)
            HUNT: begin
                if (frame) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            SHIFT: begin
                if (bit_cnt_q == CNT_W'(0)) begin
                    if (frame) begin
                        load_s = 1'b1;
                    end else begin
                        state_d      = HUNT;
                        clear_prev_s = 1'b1;
                    end
                end else if (frame) begin
                    frame_err_d  = 1'b1;
                    clear_prev_s = 1'b1;
                    load_s       = 1'b1;
                end else begin
                    shift_s = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = CNT_W'(0);
                        complete_s = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d      = HUNT;
                bit_cnt_d    = CNT_W'(0);
                clear_prev_s = 1'b1;
            end
        endcase

        if (load_s) begin
            state_d   = SHIFT;
            bit_cnt_d = CNT_W'(1);
        end else begin
            bit_cnt_d = bit_cnt_d;
        end

        sh_a_d = load_s ? {{(WIDTH-1){1'b0}}, in_a} : (shift_s ? full_a_s : sh_a_q);
        sh_b_d = load_s ? {{(WIDTH-1){1'b0}}, in_b} : (shift_s ? full_b_s : sh_b_q);

        // A handshake in the completion cycle frees the holding register.
        capture_s = complete_s & (~word_valid_q | word_ready);
        drop_s    = complete_s & ~capture_s;

        word_a_d     = capture_s ? full_a_s : word_a_q;
        word_b_d     = capture_s ? full_b_s : word_b_q;
        word_valid_d = capture_s | (word_valid_q & ~word_ready);
        seq_err_d    = capture_s & have_prev_q & seq_break(full_a_s, full_b_s, prev_a_q, prev_b_q);
        prev_a_d     = capture_s ? full_a_s : prev_a_q;
        prev_b_d     = capture_s ? full_b_s : prev_b_q;
        have_prev_d  = capture_s ? 1'b1 : (clear_prev_s ? 1'b0 : have_prev_q);
        overflow_d   = overflow_q | drop_s;

        seq_cnt_d = (seq_err_d && (seq_cnt_q != {ERR_W{1'b1}})) ? seq_cnt_q + ERR_W'(1) : seq_cnt_q;
        frm_cnt_d = (frame_err_d && (frm_cnt_q != {ERR_W{1'b1}})) ? frm_cnt_q + ERR_W'(1) : frm_cnt_q;
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= HUNT;
            bit_cnt_q    <= CNT_W'(0);
            sh_a_q       <= {WIDTH{1'b0}};
            sh_b_q       <= {WIDTH{1'b0}};
            word_a_q     <= {WIDTH{1'b0}};
            word_b_q     <= {WIDTH{1'b0}};
            prev_a_q     <= {WIDTH{1'b0}};
            prev_b_q     <= {WIDTH{1'b0}};
            have_prev_q  <= 1'b0;
            word_valid_q <= 1'b0;
            seq_err_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            seq_cnt_q    <= {ERR_W{1'b0}};
            frm_cnt_q    <= {ERR_W{1'b0}};
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sh_a_q       <= sh_a_d;
            sh_b_q       <= sh_b_d;
            word_a_q     <= word_a_d;
            word_b_q     <= word_b_d;
            prev_a_q     <= prev_a_d;
            prev_b_q     <= prev_b_d;
            have_prev_q  <= have_prev_d;
            word_valid_q <= word_valid_d;
            seq_err_q    <= seq_err_d;
            frame_err_q  <= frame_err_d;
            seq_cnt_q    <= seq_cnt_d;
            frm_cnt_q    <= frm_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    assign word_a     = word_a_q;
    assign word_b     = word_b_q;
    assign word_valid = word_valid_q;
    assign seq_err    = seq_err_q;
    assign frame_err  = frame_err_q;
    assign seq_cnt    = seq_cnt_q;
    assign frm_cnt    = frm_cnt_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_dual_lane_deserialiser.sv
// Bench for dual_lane_deserialiser: bit-queue reference model feeds a scoreboard,
// a negedge monitor pops expected pairs whenever the DUT presents a new one.
module tb_dual_lane_deserialiser;

    localparam int W   = 8;
    localparam int EW  = 3;
    localparam int M   = 1 << W;
    localparam int SAT = (1 << EW) - 1;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          frame = 1'b0;
    logic          in_a = 1'b0;
    logic          in_b = 1'b0;
    logic          word_ready = 1'b1;
    logic [W-1:0]  word_a, word_b;
    logic          word_valid, seq_err, frame_err, overflow;
    logic [EW-1:0] seq_cnt, frm_cnt;

    dual_lane_deserialiser #(.WIDTH(W), .ERR_W(EW)) dut (
        .clock(clock), .reset(reset), .frame(frame), .in_a(in_a), .in_b(in_b),
        .word_a(word_a), .word_b(word_b), .word_valid(word_valid), .word_ready(word_ready),
        .seq_err(seq_err), .frame_err(frame_err), .seq_cnt(seq_cnt), .frm_cnt(frm_cnt),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         se;
    } pair_t;
    pair_t sbq[$];

    // Reference model state, expressed as bit lists and plain integers.
    bit m_hunt = 1'b1;
    int m_bits_a[$];
    int m_bits_b[$];
    bit m_have_prev = 1'b0;
    int m_prev_a = 0, m_prev_b = 0;
    bit m_held = 1'b0, m_ovf = 1'b0, m_ferr = 1'b0;
    int m_seq_cnt = 0, m_frm_cnt = 0;

    bit rdy_rand = 1'b0;
    bit mon_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_start(input bit a, input bit b);
        m_bits_a.delete();
        m_bits_b.delete();
        m_bits_a.push_back(int'(a));
        m_bits_b.push_back(int'(b));
        m_hunt = 1'b0;
    endtask

    task automatic model_step(input bit rst, input bit f, input bit a, input bit b, input bit rdy);
        bit hs, cap, se;
        int va, vb;
        if (rst) begin
            m_hunt = 1'b1; m_bits_a.delete(); m_bits_b.delete();
            m_have_prev = 1'b0; m_held = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
            m_seq_cnt = 0; m_frm_cnt = 0; sbq.delete();
            return;
        end
        m_ferr = 1'b0;
        hs = m_held && rdy;
        cap = 1'b0;
        if (m_hunt) begin
            if (f) m_start(a, b);
        end else if (m_bits_a.size() == 0) begin
            if (f) m_start(a, b);
            else begin m_hunt = 1'b1; m_have_prev = 1'b0; end
        end else if (f) begin
            m_ferr = 1'b1;
            if (m_frm_cnt < SAT) m_frm_cnt++;
            m_have_prev = 1'b0;
            m_start(a, b);
        end else begin
            m_bits_a.push_back(int'(a));
            m_bits_b.push_back(int'(b));
            if (m_bits_a.size() == W) begin
                va = 0; vb = 0;
                for (int i = 0; i < W; i++) begin
                    va = va * 2 + m_bits_a[i];
                    vb = vb * 2 + m_bits_b[i];
                end
                m_bits_a.delete();
                m_bits_b.delete();
                if (!m_held || rdy) begin
                    se = m_have_prev && ((va != (m_prev_a + M - 1) % M) || (vb != (m_prev_b + 1) % M));
                    sbq.push_back('{a: W'(va), b: W'(vb), se: se});
                    if (se && m_seq_cnt < SAT) m_seq_cnt++;
                    m_prev_a = va; m_prev_b = vb; m_have_prev = 1'b1;
                    m_held = 1'b1; cap = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        if (hs && !cap) m_held = 1'b0;
    endtask

    task automatic drive(input bit f, input bit a, input bit b);
        if (rdy_rand) word_ready = ($urandom_range(0, 9) < 7);
        frame = f; in_a = a; in_b = b;
        @(posedge clock);
        model_step(reset, f, a, b, word_ready);
        #1;
    endtask

    task automatic send_bits(input logic [W-1:0] a, input logic [W-1:0] b, input int n);
        for (int i = 0; i < n; i++) drive(i == 0, a[W-1-i], b[W-1-i]);
    endtask

    task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b);
        send_bits(a, b, W);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        mon_on = 1'b1;
        check("reset_word_a", int'(word_a), 0);
        check("reset_word_b", int'(word_b), 0);
        check("reset_valid", int'(word_valid), 0);
        check("reset_overflow", int'(overflow), 0);
    endtask

    // Scoreboard monitor: compares pulses/counters each cycle and pops on each new pair.
    logic         prev_valid = 1'b0, prev_hs = 1'b0;
    logic [W-1:0] cur_a = '0, cur_b = '0;
    always @(negedge clock) begin
        pair_t p;
        bit    new_s;
        if (mon_on) begin
            new_s = word_valid && (!prev_valid || prev_hs);
            check("word_valid", int'(word_valid), int'(m_held));
            check("frame_err", int'(frame_err), int'(m_ferr));
            check("seq_cnt", int'(seq_cnt), m_seq_cnt);
            check("frm_cnt", int'(frm_cnt), m_frm_cnt);
            check("overflow", int'(overflow), int'(m_ovf));
            if (new_s) begin
                if (sbq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_pair: got a=%0h b=%0h expected none at %0t", word_a, word_b, $time);
                end else begin
                    p = sbq.pop_front();
                    check("pair_a", int'(word_a), int'(p.a));
                    check("pair_b", int'(word_b), int'(p.b));
                    check("seq_err", int'(seq_err), int'(p.se));
                    cur_a = p.a; cur_b = p.b;
                end
            end else begin
                check("seq_err_quiet", int'(seq_err), 0);
                if (word_valid) begin
                    check("hold_a", int'(word_a), int'(cur_a));
                    check("hold_b", int'(word_b), int'(cur_b));
                end
            end
            prev_valid = word_valid;
            prev_hs    = word_valid && word_ready;
        end
    end

    initial begin
        logic [W-1:0] ga, gb, na, nb;
        word_ready = 1'b1;
        do_reset();

        // Basic stream, ready held high.
        send_word(8'h00, 8'h80); send_word(8'hFF, 8'h81); send_word(8'hFE, 8'h82);
        idle(3);

        // Wrap on both lanes.
        do_reset();
        send_word(8'h01, 8'hFE); send_word(8'h00, 8'hFF); send_word(8'hFF, 8'h00);
        idle(2);

        // Skipped value on lane A, then clean continuation.
        do_reset();
        send_word(8'h10, 8'h20); send_word(8'h0E, 8'h21); send_word(8'h0D, 8'h22);
        idle(2);

        // Frame mid-word at bit 3.
        do_reset();
        send_word(8'h40, 8'h50); send_bits(8'h3F, 8'h51, 3);
        send_word(8'h33, 8'h77); send_word(8'h32, 8'h78);
        idle(2);

        // Back-pressure across two completed words.
        do_reset();
        word_ready = 1'b0;
        send_word(8'hA0, 8'h0A); send_word(8'h9F, 8'h0B);
        idle(2);
        word_ready = 1'b1;
        idle(3);

        // Reset in the middle of a word while a pair is held.
        word_ready = 1'b0;
        send_word(8'h90, 8'h11); send_bits(8'h8F, 8'h12, 4);
        do_reset();
        word_ready = 1'b1;
        send_word(8'h55, 8'h55); send_word(8'h54, 8'h56);
        idle(2);

        // Randomised traffic: mostly legal sequences with injected faults and stalls.
        do_reset();
        rdy_rand = 1'b1;
        ga = W'($urandom); gb = W'($urandom);
        for (int k = 0; k < 300; k++) begin
            na = ga - 8'h01; nb = gb + 8'h01;
            if ($urandom_range(0, 9) == 0) na = W'($urandom);
            if ($urandom_range(0, 19) == 0) nb = W'($urandom);
            if ($urandom_range(0, 19) == 0) send_bits(W'($urandom), W'($urandom), $urandom_range(1, W - 1));
            send_word(na, nb);
            ga = na; gb = nb;
            if ($urandom_range(0, 19) == 0) idle($urandom_range(1, 3));
        end
        rdy_rand = 1'b0;
        word_ready = 1'b1;
        idle(4);
        check("scoreboard_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
